// File: rtl/rx_pkg.sv
// Shared definitions for the 4-bit serial receiver: state encoding and default bit period.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rx_pkg;

  // Default number of core clock cycles per serial bit.
  localparam int CLKS_PER_BIT_DEF = 4;

  // Receiver states; the encoding is fixed so that debug probes can decode it directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous serial line into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples on every clock edge. Resets to 1 so an idle-high line is not mistaken for a start.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both reset to the idle-high level of the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sipo_rx_4bits.sv
// Serial-in parallel-out receiver: start bit, 4 data bits LSB first, one stop bit.
// Latency: data/load (or frame_err) appear one cycle after the mid-stop-bit sample.
// Backpressure: none; load is a one-cycle strobe the downstream register must take as presented.
module sipo_rx_4bits
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data,
  output logic       load,
  output logic       frame_err,
  output logic       busy
);

  // Timer is wide enough to count 0..CLKS_PER_BIT-1.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Sample points: middle of the start bit, then one full bit period for every later bit.
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  logic            rx_s;
  rx_state_t       state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [1:0]      idx, idx_n;
  logic [3:0]      shreg, shreg_n;
  logic [3:0]      data_n;
  logic            load_n, ferr_n;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  // State and datapath registers; reset clears everything, including the output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      load      <= load_n;
      frame_err <= ferr_n;
    end
  end

  // Next-state and datapath logic; only timer-driven sample points look at rx_s once a frame has begun.
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    load_n  = 1'b0;
    ferr_n  = 1'b0;

    case (state)
      IDLE: begin
        timer_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end

      START: begin
        if (timer == T_HALF) begin
          timer_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_n = IDLE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      DATA: begin
        if (timer == T_FULL) begin
          timer_n      = '0;
          shreg_n[idx] = rx_s;
          if (idx == 2'd3) begin
            idx_n   = '0;
            state_n = STOP;
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      STOP: begin
        if (timer == T_FULL) begin
          timer_n = '0;
          state_n = IDLE;
          if (rx_s) begin
            data_n = shreg;
            load_n = 1'b1;
          end else begin
            // Bad framing: keep the previous word, flag the error instead.
            ferr_n = 1'b1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sipo_rx_4bits.sv
// Self-checking bench for sipo_rx_4bits: directed frames, glitch, mid-frame reset, then random frames.
// Latency: expects each good frame to yield one load strobe and the downstream register to follow a cycle later.
// Backpressure: n/a; the bench drives rx bit by bit with CPB clocks per bit.
module tb_sipo_rx_4bits;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [3:0] data;
  logic       load;
  logic       frame_err;
  logic       busy;

  // Expected outcome, built from whole frames.
  logic [3:0] exp_loads[$];
  int         exp_ferr;
  logic [3:0] exp_data;

  // Observed outcome, collected by the monitor.
  logic [3:0] act_loads[$];
  logic [3:0] ds_q[$];
  int         act_ferr;
  int         width_viol_load;
  int         width_viol_ferr;
  int         both_viol;
  int         data_viol;
  logic       prev_load;
  logic       prev_ferr;
  logic [3:0] prev_data;

  // Downstream parallel register fed by data/load.
  logic [3:0] ds_reg;

  int n_assert;
  int n_fail;
  int checked;

  sipo_rx_4bits #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .load      (load),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream register: captures data whenever load is presented.
  always @(posedge clk or posedge rst) begin
    if (rst) ds_reg <= 4'h0;
    else if (load) ds_reg <= data;
  end

  // Monitor on the falling edge: records strobes and flags pulse-shape or data-stability violations.
  always @(negedge clk) begin
    if (rst) begin
      prev_load <= 1'b0;
      prev_ferr <= 1'b0;
      prev_data <= data;
    end else begin
      if (load) act_loads.push_back(data);
      if (frame_err) act_ferr <= act_ferr + 1;
      if (load && prev_load) width_viol_load <= width_viol_load + 1;
      if (frame_err && prev_ferr) width_viol_ferr <= width_viol_ferr + 1;
      if (load && frame_err) both_viol <= both_viol + 1;
      if ((data !== prev_data) && !load) data_viol <= data_viol + 1;
      if (prev_load) ds_q.push_back(ds_reg);
      prev_load <= load;
      prev_ferr <= frame_err;
      prev_data <= data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Sends one frame and records what a correct receiver must report for it.
  task automatic send_frame(input logic [3:0] w, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(w[i]);
    drive_bit(stop_b);
    if (stop_b) begin
      exp_loads.push_back(w);
      exp_data = w;
    end else begin
      exp_ferr++;
    end
  endtask

  // Lets the line idle, then compares everything received since the previous check.
  task automatic check_section(input string tag);
    rx = 1'b1;
    tick(3 * CPB);
    chk($sformatf("%s load_count", tag), act_loads.size(), exp_loads.size());
    chk($sformatf("%s ds_count", tag), ds_q.size(), exp_loads.size());
    for (int i = checked; i < exp_loads.size(); i++) begin
      if (i < act_loads.size()) chk($sformatf("%s word%0d", tag, i), act_loads[i], exp_loads[i]);
      if (i < ds_q.size()) chk($sformatf("%s ds_q%0d", tag, i), ds_q[i], exp_loads[i]);
    end
    checked = exp_loads.size();
    chk($sformatf("%s ferr_count", tag), act_ferr, exp_ferr);
    chk($sformatf("%s data_hold", tag), data, exp_data);
    chk($sformatf("%s busy_idle", tag), busy, 1'b0);
  endtask

  initial begin
    logic [3:0] w;
    logic       stop_b;
    logic       busy_seen;
    int         gap;

    n_assert = 0; n_fail = 0; checked = 0;
    exp_ferr = 0; exp_data = 4'h0;
    act_ferr = 0; width_viol_load = 0; width_viol_ferr = 0; both_viol = 0; data_viol = 0;
    rst = 1'b1;
    rx  = 1'b1;

    // Reset state.
    tick(3);
    chk("rst data", data, 4'h0);
    chk("rst load", load, 1'b0);
    chk("rst ferr", frame_err, 1'b0);
    chk("rst busy", busy, 1'b0);
    rst = 1'b0;
    tick(2 * CPB);

    // Single good frame, word 0101.
    send_frame(4'b0101, 1'b1);
    check_section("single");

    // Back-to-back frames, no idle gap.
    send_frame(4'b1010, 1'b1);
    send_frame(4'b0101, 1'b1);
    check_section("b2b");

    // Bad stop bit: frame error only, data unchanged.
    send_frame(4'b1111, 1'b0);
    check_section("ferr");

    // One-cycle low glitch while idle.
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    tick(8);
    chk("glitch busy_seen", busy_seen, 1'b1);
    check_section("glitch");

    // Reset in the middle of data bit 2, line held low through release.
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(CPB);
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(CPB / 2);
    chk("midrst busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst data", data, 4'h0);
    chk("midrst load", load, 1'b0);
    chk("midrst ferr", frame_err, 1'b0);
    chk("midrst busy", busy, 1'b0);
    exp_data = 4'h0;
    rx = 1'b0;
    tick(2);
    rst = 1'b0;
    send_frame(4'b0011, 1'b1);
    check_section("midrst");

    // Random frames with random idle gaps and occasional bad stop bits.
    for (int n = 0; n < 30; n++) begin
      w      = 4'($urandom_range(0, 15));
      stop_b = ($urandom_range(0, 3) != 0);
      send_frame(w, stop_b);
      gap = stop_b ? $urandom_range(0, 2 * CPB) : CPB + $urandom_range(0, CPB);
      rx = 1'b1;
      if (gap > 0) tick(gap);
    end
    check_section("random");

    // Pulse shape and data stability over the whole run.
    chk("load width", width_viol_load, 0);
    chk("ferr width", width_viol_ferr, 0);
    chk("load_and_ferr", both_viol, 0);
    chk("data stable", data_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_rx_4bits.md
SIPO_RX_4BITS -- requirements
Module: sipo_rx_4bits

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..256.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port data  output  4  last correctly framed word; feeds the downstream 4-bit parallel register data input.
REQ-006 SHALL have port load  output  1  one-cycle pulse marking data as new; drives the downstream register load.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; rx_s (2-cycle latency) is the only form of rx used internally.
REQ-010 SHALL implement states IDLE, START, DATA, STOP with a bit-timer counter (clog2(CLKS_PER_BIT) bits) and a 2-bit bit index.
REQ-011 IDLE: on rx_s==0 -> START, timer cleared; otherwise stay in IDLE.
REQ-012 START: when timer == CLKS_PER_BIT/2-1 (integer division), sample rx_s; 0 -> DATA with timer and index cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-013 DATA: when timer == CLKS_PER_BIT-1, sample rx_s into shift-register bit [index] (LSB first), clear timer, increment index; after index 3 -> STOP.
REQ-014 STOP: when timer == CLKS_PER_BIT-1, sample rx_s; 1 -> data <= shift register and load=1 in the next cycle; 0 -> frame_err=1 in the next cycle, data unchanged; both cases -> IDLE.
REQ-015 load and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-016 data SHALL change only in the cycle load rises and SHALL hold its value otherwise.
REQ-017 A frame starting immediately after a stop bit (no extra idle) SHALL be received; IDLE detects rx_s==0 in the cycle after leaving STOP.
REQ-018 rx activity while busy SHALL NOT restart the frame; only the timer-driven samples are used.
REQ-019 Timer SHALL wrap to 0 on every sample point; no other counter wrap-around is permitted.

Reset
REQ-020 Asserting rst at any time, including mid-frame, SHALL force within the same cycle: state IDLE, timer 0, index 0, shift register 0, data 4'b0000, load 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-021 After rst deasserts, the first frame SHALL be recognised only from a falling edge of rx seen after reset; a line already low SHALL be treated as a start after the 2-cycle synchronizer latency.

Structure
REQ-022 State encoding (localparam enum IDLE=0, START=1, DATA=2, STOP=3) and the CLKS_PER_BIT default SHALL live in the shared package rx_pkg.
REQ-023 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value 1); there are no other sub-modules.
REQ-024 Implementation SHALL be fully synchronous apart from the asynchronous reset; no latches, no gated clocks.

Verification (CLKS_PER_BIT=4)
REQ-025 Frame 0,1,0,1,0,1 (start, data LSB-first 1010 -> 4'b0101, stop) -> data=4'b0101, load high exactly 1 cycle, frame_err 0.
REQ-026 Back-to-back frames carrying 4'b1010 then 4'b0101 with no idle gap -> two load pulses, data 4'b1010 then 4'b0101.
REQ-027 Frame with data 4'b1111 and stop bit 0 -> frame_err 1 cycle, no load, data keeps its previous value.
REQ-028 rx low for 1 cycle in IDLE (glitch) -> return to IDLE, busy drops, no load/frame_err.
REQ-029 rst pulse during DATA bit 2 -> all outputs at reset values immediately; next valid frame 4'b0011 received correctly.
REQ-030 Drive the downstream 4-bit register from data/load -> its Q equals each received word one cycle after load.
